wb_dest_select_q: RTL and testbench

- Parametrised successor to the write-back destination selector in the multicycle datapath.
- Selects one of NUM_IN register-index candidates (rt, rd, $ra, $sp, constants, …) using a binary control code.
- Registers the result into a 2-entry skid queue with valid/ready handshakes on both sides, so the control unit and the register-file write stage can stall independently.
- Flags select codes outside the input range.

---
 rtl/wb_dest_select_q.sv | 111 +++++++++++
 tb/tb_wb_dest_select_q.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dest_select_q.sv
// Write-back destination selector feeding a 2-entry skid queue.
// Optional macro WB_ZERO_SUPPRESS_EN drops $zero destinations and counts them.
module wb_dest_select_q #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 6,
    parameter int CTRL_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [CTRL_W-1:0]       control,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [7:0]              suppress_cnt
);

    localparam logic [CTRL_W:0] NUM_IN_C = (CTRL_W+1)'(NUM_IN);

    logic [WIDTH-1:0] sel;
    logic             err;
    logic             sup;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] mem_d [2];
    logic [1:0]       mem_e;
    logic             head;
    logic             tail;
    logic             head_n;
    logic [1:0]       count;
    logic [1:0]       count_n;
    logic [WIDTH-1:0] nxt_d;
    logic             nxt_e;

    // Codes at or above the last candidate all alias onto it.
    always_comb begin
        sel = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NUM_IN-1; k++) begin
            if (control == CTRL_W'(k)) begin
                sel = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign err       = {1'b0, control} >= NUM_IN_C;
    assign in_ready  = (count < 2'd2) && !reset;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !sup;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_n = count + {1'b0, push} - {1'b0, pop};
        head_n  = head ^ pop;
        nxt_d   = mem_d[head_n];
        nxt_e   = mem_e[head_n];
        if (push && (tail == head_n)) begin
            nxt_d = sel;
            nxt_e = err;
        end
    end

    // out_data/sel_err are a registered copy of the next head so they
    // keep their last value once the queue drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_d[0] <= '0;
            mem_d[1] <= '0;
            mem_e    <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            out_data <= '0;
            sel_err  <= 1'b0;
        end else begin
            if (push) begin
                mem_d[tail] <= sel;
                mem_e[tail] <= err;
                tail        <= ~tail;
            end
            head  <= head_n;
            count <= count_n;
            if (count_n != 2'd0) begin
                out_data <= nxt_d;
                sel_err  <= nxt_e;
            end
        end
    end

`ifdef WB_ZERO_SUPPRESS_EN
    logic [7:0] sup_q;

    assign sup          = in_valid && in_ready && !err && (sel == '0);
    assign suppress_cnt = sup_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sup_q <= 8'd0;
        end else if (sup && (sup_q != 8'hff)) begin
            sup_q <= sup_q + 8'd1;
        end
    end
`else
    assign sup          = 1'b0;
    assign suppress_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_wb_dest_select_q.sv
// Bench for wb_dest_select_q: vector table plus scoreboard of queued entries.
// Honours WB_ZERO_SUPPRESS_EN the same way the design does.
module tb_wb_dest_select_q;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] in_data;
    logic [2:0]  control;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;
    logic [7:0]  suppress_cnt;

    wb_dest_select_q dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .control      (control),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sel_err      (sel_err),
        .suppress_cnt (suppress_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ctrl;
        logic [4:0] d;
        logic       e;
    } vec_t;

    typedef struct packed {
        logic [4:0] d;
        logic       e;
    } exp_t;

    vec_t tbl [8];
    exp_t sb [$];

    int   checks = 0;
    int   errors = 0;
    int   exp_sup = 0;
    logic accepted = 1'b0;
    logic [4:0] exp_d = '0;
    logic       exp_e = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Scoreboard: compare pops, then record accepted pushes.
    always @(negedge clk) begin
        exp_t e;
        accepted = 1'b0;
        if (reset) begin
            sb.delete();
        end else begin
            chk("out_valid_vs_model", out_valid, sb.size() != 0);
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_data", out_data, e.d);
                chk("pop_err", sel_err, e.e);
            end
            if (in_valid && in_ready) begin
                accepted = 1'b1;
`ifdef WB_ZERO_SUPPRESS_EN
                if (exp_d == 5'd0 && !exp_e) begin
                    if (exp_sup < 255) exp_sup++;
                end else begin
                    sb.push_back('{d: exp_d, e: exp_e});
                end
`else
                sb.push_back('{d: exp_d, e: exp_e});
`endif
            end
        end
    end

    task automatic send(input logic [2:0] c, input logic [4:0] d,
                        input logic e);
        bit got = 0;
        control  = c;
        exp_d    = d;
        exp_e    = e;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (accepted) begin
                got = 1;
                break;
            end
        end
        #1;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: got 0 expected 1 (ctrl %0d)", c);
        end
    endtask

    initial begin
        tbl[0] = '{3'd0, 5'd3,  1'b0};
        tbl[1] = '{3'd1, 5'd8,  1'b0};
        tbl[2] = '{3'd2, 5'd9,  1'b0};
        tbl[3] = '{3'd3, 5'd17, 1'b0};
        tbl[4] = '{3'd4, 5'd29, 1'b0};
        tbl[5] = '{3'd5, 5'd31, 1'b0};
        tbl[6] = '{3'd6, 5'd31, 1'b1};
        tbl[7] = '{3'd7, 5'd31, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        control   = 3'd0;
        in_data   = {5'd31, 5'd29, 5'd17, 5'd9, 5'd8, 5'd3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_suppress", suppress_cnt, 0);
        @(posedge clk);
        #1;

        // Single push, one-cycle latency.
        out_ready = 1'b1;
        send(3'd3, 5'd17, 1'b0);
        in_valid = 1'b0;
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data", out_data, 17);
        chk("lat_sel_err", sel_err, 0);
        @(posedge clk);
        #1;

        // Table: every code streamed back to back.
        foreach (tbl[i]) begin
            send(tbl[i].ctrl, tbl[i].d, tbl[i].e);
            if (i > 0) chk("stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 0);
        chk("hold_data", out_data, 31);
        chk("hold_err", sel_err, 1);

        // Fill, stall, refuse third, then drain.
        out_ready = 1'b0;
        send(3'd0, 5'd3, 1'b0);
        send(3'd2, 5'd9, 1'b0);
        control  = 3'd4;
        exp_d    = 5'd29;
        exp_e    = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("stall_data", out_data, 3);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("after_pop_in_ready", in_ready, 1);
        chk("after_pop_data", out_data, 9);
        @(posedge clk);
        #1;
        chk("drained_valid", out_valid, 0);

        // Continuous push/pop at count=1.
        for (int c = 0; c < 5; c++) begin
            send(tbl[c].ctrl, tbl[c].d, tbl[c].e);
            chk("cont_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset with two entries queued.
        out_ready = 1'b0;
        send(3'd1, 5'd8, 1'b0);
        send(3'd4, 5'd29, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_err", sel_err, 0);
        out_ready = 1'b1;
        send(3'd2, 5'd9, 1'b0);
        in_valid = 1'b0;
        chk("postrst_data", out_data, 9);
        @(posedge clk);
        #1;

        // Zero destination.
        in_data = {5'd31, 5'd29, 5'd17, 5'd9, 5'd8, 5'd0};
        repeat (3) send(3'd0, 5'd0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("suppress_cnt", suppress_cnt, exp_sup);
`ifdef WB_ZERO_SUPPRESS_EN
        chk("suppress_expected", exp_sup, 3);
`endif
        @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
